// File: rtl/lsu_msinc_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_msinc_ctrl
//   Load/store initiator between the MEM stage and the word-wide data memory
//   (msinc_Data). Accepts byte/half/word requests on byte addresses, rejects
//   misaligned or illegal sizes, sign/zero-extends load data, and performs
//   sub-word stores as read-modify-write because the memory has no byte
//   enables. Little-endian lane order.
//
//   Build option: define LSU_BOUNDS_CHECK_EN to reject addresses whose bits
//   above the memory range are non-zero. Without it those bits are ignored
//   and accesses alias modulo 2**AW words.
//
// Ports
//   clk_i        clock, all state changes on posedge
//   rst_ni       synchronous active-low reset
//   req_i        request, sampled only while ready_o=1
//   we_i         1=store, 0=load
//   size_i       00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i   loads: 1=zero-extend, 0=sign-extend
//   addr_i       byte address
//   wdata_i      right-aligned store data
//   ready_o      high in IDLE only
//   done_o       one-cycle completion pulse
//   err_o        qualifies done_o: request rejected, no memory access
//   rdata_o      extended load data, held until the next load completes
//   mem_we_o     memory write enable
//   mem_re_o     memory read enable
//   mem_addr_o   memory word address (captured addr[AW+1:2])
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid by the end of the RE cycle
// ---------------------------------------------------------------------------
module lsu_msinc_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          ready_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   rdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP,
    S_ERR
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        misalign_c;
  logic        oob_c;
  logic        bad_c;

  // Alignment / size legality of the incoming request
  always_comb begin
    misalign_c = 1'b0;
    case (size_i)
      SZ_B:    misalign_c = 1'b0;
      SZ_H:    misalign_c = addr_i[0];
      SZ_W:    misalign_c = |addr_i[1:0];
      default: misalign_c = 1'b1;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  // Upper address bits must be zero; anything else is outside the memory
  assign oob_c = |addr_i[31:AW+2];
`else
  logic unused_addr_hi;
  assign oob_c          = 1'b0;
  assign unused_addr_hi = ^addr_i[31:AW+2];
`endif

  assign bad_c = misalign_c | oob_c;

  // Pick the addressed lane out of a memory word and extend it
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  // Replace the addressed lane of a memory word with the store data
  function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane,
                                             input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == SZ_B) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    lane_merge = r;
  endfunction

  // Control FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
      rdata_o     <= 32'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
    end else begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      mem_we_o <= 1'b0;
      mem_re_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_i) begin
            ready_o <= 1'b0;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            lane_q  <= addr_i[1:0];
            wdata_q <= wdata_i[15:0];
            if (bad_c) begin
              state  <= S_ERR;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              mem_addr_o <= addr_i[AW+1:2];
              if (!we_i) begin
                state    <= S_RD;
                mem_re_o <= 1'b1;
              end else if (size_i == SZ_W) begin
                state       <= S_WR;
                mem_we_o    <= 1'b1;
                mem_wdata_o <= wdata_i;
              end else begin
                state    <= S_RMW_RD;
                mem_re_o <= 1'b1;
              end
            end
          end
        end

        S_RD: begin
          rdata_o <= load_extend(mem_rdata_i, size_q, lane_q, uns_q);
          state   <= S_RESP;
          done_o  <= 1'b1;
        end

        S_WR: begin
          state  <= S_RESP;
          done_o <= 1'b1;
        end

        // Old word is on mem_rdata_i now; write back with the lane replaced
        S_RMW_RD: begin
          mem_wdata_o <= lane_merge(mem_rdata_i, size_q, lane_q, wdata_q);
          mem_we_o    <= 1'b1;
          state       <= S_RMW_WR;
        end

        S_RMW_WR: begin
          state  <= S_RESP;
          done_o <= 1'b1;
        end

        S_RESP, S_ERR: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
